// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle control unit for the Lab 3 datapath.
//
// Walks every instruction through IDLE/IF/ID/EXE/MEM/WB. The control outputs
// are decoded combinationally from the state register together with op, funct
// and zero. Because of this, an asynchronous reset clears every output at
// once, without waiting for a clock edge.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   op        in   IR[31:26], held by the IR after IF
//   funct     in   IR[5:0]
//   zero      in   ALU result == 0, only looked at in EXE of beq
//   aluop     out  ALU operation code
//   pcwr      out  PC write enable
//   irwr      out  IR write enable
//   npcop     out  next-PC select: 00 PC+4, 01 branch target, 10 jump target
//   alusrcb   out  ALU B select: 0 rt, 1 extended immediate
//   extop     out  immediate extension: 0 zero-extend, 1 sign-extend
//   memwr     out  data memory write enable
//   regwr     out  register file write enable
//   regdst    out  destination register: 1 rd, 0 rt
//   memtoreg  out  write-back source: 1 memory data, 0 ALU output register
//   retire    out  pulse in the last cycle of each instruction
//   illegal   out  pulse in ID for an unsupported op/funct
//   state     out  current state, for debug
// -----------------------------------------------------------------------------
module mc_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [5:0] aluop,
   output logic       pcwr,
   output logic       irwr,
   output logic [1:0] npcop,
   output logic       alusrcb,
   output logic       extop,
   output logic       memwr,
   output logic       regwr,
   output logic       regdst,
   output logic       memtoreg,
   output logic       retire,
   output logic       illegal,
   output logic [2:0] state
);

   // ALU operation encodings, matching the codes the shared ALU decodes.
   localparam logic [5:0] ALU_ADDU = 6'd0;
   localparam logic [5:0] ALU_SUBU = 6'd1;
   localparam logic [5:0] ALU_ADD  = 6'd2;
   localparam logic [5:0] ALU_AND  = 6'd3;
   localparam logic [5:0] ALU_OR   = 6'd4;
   localparam logic [5:0] ALU_SLT  = 6'd5;
   localparam logic [5:0] ALU_LUI  = 6'd6;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EXE  = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5
   } state_t;

   state_t     state_r;
   state_t     next_state_s;
   logic [5:0] r_aluop_s;
   logic       r_ok_s;
   logic       supported_s;

   assign state = state_r;

   // Map R-type funct to an ALU operation and flag unsupported functs.
   always_comb begin
      r_aluop_s = ALU_ADDU;
      r_ok_s    = 1'b1;
      case (funct)
         FN_ADDU: r_aluop_s = ALU_ADDU;
         FN_SUBU: r_aluop_s = ALU_SUBU;
         FN_ADD:  r_aluop_s = ALU_ADD;
         FN_AND:  r_aluop_s = ALU_AND;
         FN_OR:   r_aluop_s = ALU_OR;
         FN_SLT:  r_aluop_s = ALU_SLT;
         default: begin
            r_aluop_s = ALU_ADDU;
            r_ok_s    = 1'b0;
         end
      endcase
   end

   // Decide whether the instruction in the IR is one this unit can sequence.
   always_comb begin
      supported_s = 1'b1;
      case (op)
         OP_RTYPE: supported_s = r_ok_s;
         OP_ORI, OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J: supported_s = 1'b1;
         default:  supported_s = 1'b0;
      endcase
   end

   // State register; reset returns to IDLE without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and control outputs for the current state.
   always_comb begin
      next_state_s = S_IDLE;
      aluop        = ALU_ADDU;
      pcwr         = 1'b0;
      irwr         = 1'b0;
      npcop        = 2'b00;
      alusrcb      = 1'b0;
      extop        = 1'b0;
      memwr        = 1'b0;
      regwr        = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      retire       = 1'b0;
      illegal      = 1'b0;
      case (state_r)
         S_IDLE: begin
            next_state_s = S_IF;
         end
         S_IF: begin
            pcwr         = 1'b1;
            irwr         = 1'b1;
            npcop        = 2'b00;
            next_state_s = S_ID;
         end
         S_ID: begin
            if (op == OP_J) begin
               pcwr         = 1'b1;
               npcop        = 2'b10;
               retire       = 1'b1;
               next_state_s = S_IF;
            end else if (!supported_s) begin
               // Retire the bad instruction with no architectural write.
               illegal      = 1'b1;
               retire       = 1'b1;
               next_state_s = S_IF;
            end else begin
               next_state_s = S_EXE;
            end
         end
         S_EXE: begin
            case (op)
               OP_RTYPE: begin
                  aluop        = r_aluop_s;
                  alusrcb      = 1'b0;
                  next_state_s = S_WB;
               end
               OP_ORI: begin
                  aluop        = ALU_OR;
                  alusrcb      = 1'b1;
                  extop        = 1'b0;
                  next_state_s = S_WB;
               end
               OP_ADDIU: begin
                  aluop        = ALU_ADDU;
                  alusrcb      = 1'b1;
                  extop        = 1'b1;
                  next_state_s = S_WB;
               end
               OP_LW, OP_SW: begin
                  aluop        = ALU_ADDU;
                  alusrcb      = 1'b1;
                  extop        = 1'b1;
                  next_state_s = S_MEM;
               end
               OP_LUI: begin
                  aluop        = ALU_LUI;
                  alusrcb      = 1'b1;
                  next_state_s = S_WB;
               end
               OP_BEQ: begin
                  // The branch resolves here; PC is loaded only when equal.
                  aluop        = ALU_SUBU;
                  alusrcb      = 1'b0;
                  npcop        = 2'b01;
                  pcwr         = zero;
                  retire       = 1'b1;
                  next_state_s = S_IF;
               end
               default: begin
                  next_state_s = S_IF;
               end
            endcase
         end
         S_MEM: begin
            if (op == OP_SW) begin
               // Hold the address path so memory sees the same effective address.
               memwr        = 1'b1;
               alusrcb      = 1'b1;
               extop        = 1'b1;
               retire       = 1'b1;
               next_state_s = S_IF;
            end else begin
               next_state_s = S_WB;
            end
         end
         S_WB: begin
            regwr        = 1'b1;
            retire       = 1'b1;
            regdst       = (op == OP_RTYPE);
            memtoreg     = (op == OP_LW);
            next_state_s = S_IF;
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- directed self-checking bench for mc_ctrl.
//
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point. Every cycle's outputs are packed into one vector, and each
// task compares that vector with hand-written expected vectors.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

   localparam logic [5:0] A_ADDU = 6'd0;
   localparam logic [5:0] A_SUBU = 6'd1;
   localparam logic [5:0] A_ADD  = 6'd2;
   localparam logic [5:0] A_AND  = 6'd3;
   localparam logic [5:0] A_OR   = 6'd4;
   localparam logic [5:0] A_SLT  = 6'd5;
   localparam logic [5:0] A_LUI  = 6'd6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic [5:0] aluop;
   logic       pcwr, irwr, alusrcb, extop, memwr, regwr, regdst, memtoreg, retire, illegal;
   logic [1:0] npcop;
   logic [2:0] state;

   logic [20:0] outs;
   logic [20:0] e_if, e_id, e_zero;
   int chk_n  = 0;
   int pass_n = 0;

   mc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .aluop(aluop), .pcwr(pcwr), .irwr(irwr), .npcop(npcop),
      .alusrcb(alusrcb), .extop(extop), .memwr(memwr), .regwr(regwr),
      .regdst(regdst), .memtoreg(memtoreg), .retire(retire),
      .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign outs = {aluop, pcwr, irwr, npcop, alusrcb, extop, memwr, regwr,
                  regdst, memtoreg, retire, illegal, state};

   // Pack an expected output set in the same order as outs.
   function automatic logic [20:0] ev(input logic [5:0] a, input logic pw, input logic iw,
                                      input logic [1:0] np, input logic bs, input logic ex,
                                      input logic mw, input logic rw, input logic rd,
                                      input logic mr, input logic rt, input logic il,
                                      input logic [2:0] st);
      return {a, pw, iw, np, bs, ex, mw, rw, rd, mr, rt, il, st};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_n++;
         if (outs !== e_zero) $display("FAIL reset_hold c%0d: got %h want %h", i, outs, e_zero);
         else pass_n++;
      end
      rst_n = 1'b1;
      step();
      chk_n++;
      if (outs !== e_if) $display("FAIL reset_first_if: got %h want %h", outs, e_if);
      else pass_n++;
   endtask

   task automatic test_addu();
      logic [20:0] exp[5];
      exp[0] = e_if;
      exp[1] = e_id;
      exp[2] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      exp[3] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5);
      exp[4] = e_if;
      op = 6'b000000; funct = 6'b100001; zero = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk_n++;
         if (outs !== exp[i]) $display("FAIL addu c%0d: got %h want %h", i, outs, exp[i]);
         else pass_n++;
         if (i < 4) step();
      end
   endtask

   task automatic test_rtype_alu();
      logic [5:0] fn[5];
      logic [5:0] al[5];
      logic [20:0] want;
      fn = '{6'b100011, 6'b100000, 6'b100100, 6'b100101, 6'b101010};
      al = '{A_SUBU, A_ADD, A_AND, A_OR, A_SLT};
      for (int k = 0; k < 5; k++) begin
         op = 6'b000000; funct = fn[k]; zero = 1'b0;
         step();
         step();
         want = ev(al[k], 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
         chk_n++;
         if (outs !== want) $display("FAIL rtype_exe f%b: got %h want %h", fn[k], outs, want);
         else pass_n++;
         step();
         step();
         chk_n++;
         if (outs !== e_if) $display("FAIL rtype_next_if f%b: got %h want %h", fn[k], outs, e_if);
         else pass_n++;
      end
   endtask

   task automatic test_itype();
      logic [5:0] opc[3];
      logic [20:0] ex_exp[3];
      logic [20:0] wb_exp;
      opc = '{6'b001101, 6'b001001, 6'b001111};
      ex_exp[0] = ev(A_OR,   1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      ex_exp[1] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      ex_exp[2] = ev(A_LUI,  1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      wb_exp    = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
      for (int k = 0; k < 3; k++) begin
         op = opc[k]; funct = 6'b100100; zero = 1'b1;
         step();
         step();
         chk_n++;
         if (outs !== ex_exp[k]) $display("FAIL itype_exe op%b: got %h want %h", opc[k], outs, ex_exp[k]);
         else pass_n++;
         step();
         chk_n++;
         if (outs !== wb_exp) $display("FAIL itype_wb op%b: got %h want %h", opc[k], outs, wb_exp);
         else pass_n++;
         step();
         chk_n++;
         if (outs !== e_if) $display("FAIL itype_next_if op%b: got %h want %h", opc[k], outs, e_if);
         else pass_n++;
      end
   endtask

   task automatic test_lw_sw();
      logic [20:0] lw_exp[6];
      logic [20:0] sw_exp[5];
      lw_exp[0] = e_if;
      lw_exp[1] = e_id;
      lw_exp[2] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      lw_exp[3] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
      lw_exp[4] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5);
      lw_exp[5] = e_if;
      op = 6'b100011; funct = 6'b000000; zero = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk_n++;
         if (outs !== lw_exp[i]) $display("FAIL lw c%0d: got %h want %h", i, outs, lw_exp[i]);
         else pass_n++;
         if (i < 5) step();
      end
      sw_exp[0] = e_if;
      sw_exp[1] = e_id;
      sw_exp[2] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
      sw_exp[3] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4);
      sw_exp[4] = e_if;
      op = 6'b101011; funct = 6'b100001; zero = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_n++;
         if (outs !== sw_exp[i]) $display("FAIL sw c%0d: got %h want %h", i, outs, sw_exp[i]);
         else pass_n++;
         if (i < 4) step();
      end
   endtask

   task automatic test_beq();
      logic [20:0] want;
      for (int z = 1; z >= 0; z--) begin
         op = 6'b000100; funct = 6'b000000; zero = z[0];
         step();
         chk_n++;
         if (outs !== e_id) $display("FAIL beq_id z%0d: got %h want %h", z, outs, e_id);
         else pass_n++;
         step();
         want = ev(A_SUBU, z[0], 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
         chk_n++;
         if (outs !== want) $display("FAIL beq_exe z%0d: got %h want %h", z, outs, want);
         else pass_n++;
         step();
         chk_n++;
         if (outs !== e_if) $display("FAIL beq_next_if z%0d: got %h want %h", z, outs, e_if);
         else pass_n++;
      end
   endtask

   task automatic test_j_illegal();
      logic [5:0] opc[3];
      logic [5:0] fnc[3];
      logic [20:0] id_exp[3];
      opc = '{6'b000010, 6'b111111, 6'b000000};
      fnc = '{6'b100001, 6'b100001, 6'b000000};
      id_exp[0] = ev(A_ADDU, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
      id_exp[1] = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2);
      id_exp[2] = id_exp[1];
      for (int k = 0; k < 3; k++) begin
         op = opc[k]; funct = fnc[k]; zero = 1'b1;
         step();
         chk_n++;
         if (outs !== id_exp[k]) $display("FAIL jill_id k%0d: got %h want %h", k, outs, id_exp[k]);
         else pass_n++;
         step();
         chk_n++;
         if (outs !== e_if) $display("FAIL jill_next_if k%0d: got %h want %h", k, outs, e_if);
         else pass_n++;
      end
   endtask

   task automatic test_midop_reset();
      logic [20:0] wb_exp;
      wb_exp = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
      op = 6'b001101; funct = 6'b000000; zero = 1'b0;
      step();
      step();
      step();
      chk_n++;
      if (outs !== wb_exp) $display("FAIL midrst_wb: got %h want %h", outs, wb_exp);
      else pass_n++;
      #2;
      rst_n = 1'b0;
      #1;
      chk_n++;
      if (outs !== e_zero) $display("FAIL midrst_async: got %h want %h", outs, e_zero);
      else pass_n++;
      step();
      chk_n++;
      if (outs !== e_zero) $display("FAIL midrst_hold: got %h want %h", outs, e_zero);
      else pass_n++;
      rst_n = 1'b1;
      step();
      chk_n++;
      if (outs !== e_if) $display("FAIL midrst_if: got %h want %h", outs, e_if);
      else pass_n++;
      step();
      chk_n++;
      if (outs !== e_id) $display("FAIL midrst_id: got %h want %h", outs, e_id);
      else pass_n++;
   endtask

   initial begin
      e_zero = 21'd0;
      e_if   = ev(A_ADDU, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
      e_id   = ev(A_ADDU, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
      test_reset();
      test_addu();
      test_rtype_alu();
      test_itype();
      test_lw_sw();
      test_beq();
      test_j_illegal();
      test_midop_reset();
      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end

endmodule
